// File: rtl/amm_rdwr_pkg.sv
// Shared types and constants for the Avalon-MM read/write demo master.
package amm_rdwr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_REQ  = 2'd2,
      RD_WAIT = 2'd3
   } state_t;

   localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;
   localparam logic [3:0]  BYTEENABLE_ALL  = 4'hF;

endpackage

// File: rtl/amm_rdwr_master_if.sv
// Avalon-MM bus between the demo master and the SDRAM controller slave port.
interface amm_rdwr_master_if #(
   parameter int ADDRESSWIDTH = 28,
   parameter int DATAWIDTH    = 32
);
   logic [ADDRESSWIDTH-1:0] avm_address;
   logic                    avm_read;
   logic                    avm_write;
   logic [DATAWIDTH-1:0]    avm_writedata;
   logic [DATAWIDTH/8-1:0]  avm_byteenable;
   logic [DATAWIDTH-1:0]    avm_readdata;
   logic                    avm_waitrequest;
   logic                    avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );
endinterface

// File: rtl/amm_rdwr_master_key_debounce.sv
// Synchronizes the action key, requires a stable level for DEBOUNCE_CYCLES, and
// emits a one-cycle press pulse on the debounced falling edge.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic n_action,
   output logic press
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2, level;
   logic [CW-1:0] cnt;

   // Synchronizer resets to the released level so reset never fakes a press.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= LOAD;
         press <= 1'b0;
      end else begin
         sync1 <= n_action;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= LOAD;
         end else if (cnt == '0) begin
            level <= sync2;
            cnt   <= LOAD;
            press <= level & ~sync2;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: rtl/amm_rdwr_master.sv
// Avalon-MM master turning switch/key input into single 32-bit SDRAM transfers
// and presenting address, write data or read data on the hex display bus.
module amm_rdwr_master
   import amm_rdwr_pkg::*;
#(
   parameter int          ADDRESSWIDTH    = 28,
   parameter int          DATAWIDTH       = 32,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter int          TIMEOUT_CYCLES  = 65535
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rdwr_cntl,
   input  logic                n_action,
   input  logic                add_data_sel,
   input  logic [15:0]         rdwr_address,
   output logic [31:0]         display_data,
   output logic                busy,
   output logic                error,
   amm_rdwr_master_if.master   avm
);
   // state   | meaning
   // IDLE    | waiting for a press; address phase latches the word address
   // WR      | write request held until the slave drops waitrequest
   // RD_REQ  | read request held until the slave drops waitrequest
   // RD_WAIT | read accepted, waiting for readdatavalid

   localparam logic [ADDRESSWIDTH-1:0] BASE_TRUNC = ADDRESSWIDTH'(BASE_ADDR);
   localparam logic [31:0]             TMO_LOAD   = 32'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic                    press;
   logic [1:0]              rdwr_sync, sel_sync;
   logic [15:0]             sw_sync1, sw_sync2;
   logic [ADDRESSWIDTH-1:0] address_q;
   logic [DATAWIDTH-1:0]    wdata_q;
   logic                    read_q, write_q;
   logic [31:0]             tmo_cnt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .n_action (n_action),
      .press    (press)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdwr_sync <= '0;
         sel_sync  <= '0;
         sw_sync1  <= '0;
         sw_sync2  <= '0;
      end else begin
         rdwr_sync <= {rdwr_sync[0], rdwr_cntl};
         sel_sync  <= {sel_sync[0], add_data_sel};
         sw_sync1  <= rdwr_address;
         sw_sync2  <= sw_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         address_q    <= BASE_TRUNC;
         wdata_q      <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         display_data <= '0;
         error        <= 1'b0;
         tmo_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (press) begin
                  if (!sel_sync[1]) begin
                     address_q    <= BASE_TRUNC + ADDRESSWIDTH'({sw_sync2, 2'b00});
                     display_data <= {16'h0, sw_sync2};
                  end else if (rdwr_sync[1]) begin
                     wdata_q <= DATAWIDTH'(sw_sync2);
                     write_q <= 1'b1;
                     tmo_cnt <= TMO_LOAD;
                     state   <= WR;
                  end else begin
                     read_q  <= 1'b1;
                     tmo_cnt <= TMO_LOAD;
                     state   <= RD_REQ;
                  end
               end
            end
            WR: begin
               if (!avm.avm_waitrequest) begin
                  write_q      <= 1'b0;
                  display_data <= 32'(wdata_q);
                  state        <= IDLE;
               end else if (tmo_cnt == '0) begin
                  write_q      <= 1'b0;
                  display_data <= TIMEOUT_PATTERN;
                  error        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            RD_REQ: begin
               if (!avm.avm_waitrequest) begin
                  read_q <= 1'b0;
                  state  <= RD_WAIT;
                  if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
               end else if (tmo_cnt == '0) begin
                  read_q       <= 1'b0;
                  display_data <= TIMEOUT_PATTERN;
                  error        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            RD_WAIT: begin
               if (avm.avm_readdatavalid) begin
                  display_data <= 32'(avm.avm_readdata);
                  state        <= IDLE;
               end else if (tmo_cnt == '0) begin
                  display_data <= TIMEOUT_PATTERN;
                  error        <= 1'b1;
                  state        <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy               = (state != IDLE);
   assign avm.avm_address    = address_q;
   assign avm.avm_read       = read_q;
   assign avm.avm_write      = write_q;
   assign avm.avm_writedata  = wdata_q;
   assign avm.avm_byteenable = BYTEENABLE_ALL;
endmodule

// File: tb/tb_amm_rdwr_master.sv
// Self-checking bench for amm_rdwr_master with a behavioural Avalon slave and memory model.
module tb_amm_rdwr_master;
   localparam int AW  = 28;
   localparam int DBC = 4;
   localparam int TMO = 16;
   localparam int unsigned BASE = 0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rdwr_cntl = 1'b0;
   logic        n_action = 1'b1;
   logic        add_data_sel = 1'b0;
   logic [15:0] rdwr_address = '0;
   logic [31:0] display_data;
   logic        busy, error;

   amm_rdwr_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(32)) bus ();

   amm_rdwr_master #(
      .ADDRESSWIDTH(AW), .DATAWIDTH(32), .BASE_ADDR(BASE),
      .DEBOUNCE_CYCLES(DBC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rdwr_cntl(rdwr_cntl), .n_action(n_action),
      .add_data_sel(add_data_sel), .rdwr_address(rdwr_address),
      .display_data(display_data), .busy(busy), .error(error), .avm(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // slave configuration and observation
   int          wait_n = 0;
   int          rd_lat = 0;
   bit          hang = 0;
   int          wcnt = 0;
   bit          rd_pend = 0;
   int          rd_cnt = 0;
   logic [27:0] rd_addr;
   int          rd_count = 0, wr_count = 0, rd_high = 0, wr_high = 0;
   logic [27:0] acc_addr = '0;
   logic [31:0] acc_data = '0;
   logic [31:0] smem [logic [27:0]];

   // reference model
   logic [31:0] model_mem [logic [27:0]];
   logic [27:0] m_addr = 28'(BASE);
   logic [31:0] m_disp = '0;

   function automatic logic [27:0] exp_addr(input logic [15:0] a);
      longint unsigned s;
      s = longint'(BASE) + longint'(a) * 4;
      return 28'(s % (64'd1 << 28));
   endfunction

   initial begin
      bus.avm_readdata      = '0;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      forever begin
         @(negedge clk);
         bus.avm_readdatavalid = 1'b0;
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               bus.avm_readdatavalid = 1'b1;
               bus.avm_readdata = smem.exists(rd_addr) ? smem[rd_addr] : 32'h0;
               rd_pend = 0;
            end else rd_cnt--;
         end
         if (bus.avm_read) rd_high++;
         if (bus.avm_write) wr_high++;
         if (hang) begin
            bus.avm_waitrequest = 1'b1;
         end else if (bus.avm_read || bus.avm_write) begin
            if (wcnt < wait_n) begin
               bus.avm_waitrequest = 1'b1;
               wcnt++;
            end else begin
               bus.avm_waitrequest = 1'b0;
               wcnt = 0;
               acc_addr = bus.avm_address;
               if (bus.avm_write) begin
                  smem[bus.avm_address] = bus.avm_writedata;
                  acc_data = bus.avm_writedata;
                  wr_count++;
               end else begin
                  rd_pend = 1;
                  rd_cnt  = rd_lat;
                  rd_addr = bus.avm_address;
                  rd_count++;
               end
            end
         end else begin
            bus.avm_waitrequest = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      m_addr = 28'(BASE);
      m_disp = '0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s: busy still high after %0d cycles (required low)", name, n);
      end
   endtask

   task automatic press_key(input int hold, input string name);
      @(negedge clk);
      n_action = 1'b0;
      repeat (hold) @(negedge clk);
      n_action = 1'b1;
      repeat (DBC + 6) @(negedge clk);
      wait_idle(name);
   endtask

   task automatic latch_addr(input logic [15:0] a);
      add_data_sel = 1'b0;
      rdwr_address = a;
      press_key(10, "latch");
      m_addr = exp_addr(a);
      m_disp = {16'h0, a};
   endtask

   task automatic do_write(input logic [15:0] d);
      add_data_sel = 1'b1;
      rdwr_cntl    = 1'b1;
      rdwr_address = d;
      press_key(10, "write");
      model_mem[m_addr] = {16'h0, d};
      m_disp = {16'h0, d};
   endtask

   task automatic do_read();
      add_data_sel = 1'b1;
      rdwr_cntl    = 1'b0;
      rdwr_address = 16'h5A5A;
      press_key(10, "read");
      m_disp = model_mem.exists(m_addr) ? model_mem[m_addr] : 32'h0;
   endtask

   task automatic test_reset();
      do_reset();
      total += 8;
      if (display_data !== 32'h0) begin bad++; $display("FAIL rst_display got %h exp 0", display_data); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
      if (error !== 1'b0) begin bad++; $display("FAIL rst_error got %b exp 0", error); end
      if (bus.avm_read !== 1'b0) begin bad++; $display("FAIL rst_read got %b exp 0", bus.avm_read); end
      if (bus.avm_write !== 1'b0) begin bad++; $display("FAIL rst_write got %b exp 0", bus.avm_write); end
      if (bus.avm_address !== 28'(BASE)) begin bad++; $display("FAIL rst_address got %h exp %h", bus.avm_address, 28'(BASE)); end
      if (bus.avm_writedata !== 32'h0) begin bad++; $display("FAIL rst_writedata got %h exp 0", bus.avm_writedata); end
      if (bus.avm_byteenable !== 4'hF) begin bad++; $display("FAIL rst_byteenable got %h exp F", bus.avm_byteenable); end
   endtask

   task automatic test_addr_latch();
      int r0 = rd_count, w0 = wr_count;
      latch_addr(16'h0012);
      total += 3;
      if (display_data !== 32'h0000_0012) begin bad++; $display("FAIL latch_display got %h exp 00000012", display_data); end
      if (rd_count != r0 || wr_count != w0) begin bad++; $display("FAIL latch_bus got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_count, wr_count, r0, w0); end
      if (bus.avm_address !== 28'h48) begin bad++; $display("FAIL latch_address got %h exp 0000048", bus.avm_address); end
   endtask

   task automatic test_write();
      int h0 = wr_high;
      wait_n = 3;
      do_write(16'hBEEF);
      wait_n = 0;
      total += 4;
      if (wr_high - h0 != 4) begin bad++; $display("FAIL write_high got %0d exp 4", wr_high - h0); end
      if (acc_addr !== 28'h48) begin bad++; $display("FAIL write_addr got %h exp 0000048", acc_addr); end
      if (acc_data !== 32'h0000_BEEF) begin bad++; $display("FAIL write_data got %h exp 0000BEEF", acc_data); end
      if (display_data !== 32'h0000_BEEF) begin bad++; $display("FAIL write_display got %h exp 0000BEEF", display_data); end
   endtask

   task automatic test_read();
      int h0 = rd_high;
      smem[28'h48] = 32'hCAFE_F00D;
      model_mem[28'h48] = 32'hCAFE_F00D;
      rd_lat = 1;
      do_read();
      total += 3;
      if (rd_high - h0 != 1) begin bad++; $display("FAIL read_high got %0d exp 1", rd_high - h0); end
      if (display_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL read_display got %h exp CAFEF00D", display_data); end
      if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got %b exp 0", busy); end
   endtask

   task automatic test_bounce();
      int w0 = wr_count;
      add_data_sel = 1'b1;
      rdwr_cntl    = 1'b1;
      rdwr_address = 16'h1357;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         n_action = 1'b0;
         repeat (2) @(negedge clk);
         n_action = 1'b1;
         repeat (3) @(negedge clk);
      end
      n_action = 1'b0;
      repeat (6) @(negedge clk);
      n_action = 1'b1;
      repeat (DBC + 6) @(negedge clk);
      wait_idle("bounce");
      model_mem[m_addr] = 32'h0000_1357;
      total += 2;
      if (wr_count - w0 != 1) begin bad++; $display("FAIL bounce_count got %0d exp 1", wr_count - w0); end
      if (display_data !== 32'h0000_1357) begin bad++; $display("FAIL bounce_display got %h exp 00001357", display_data); end
   endtask

   task automatic test_random();
      logic [15:0] addrs [$];
      logic [15:0] a, d;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom);
         d = 16'($urandom);
         wait_n = $urandom_range(0, 3);
         latch_addr(a);
         total++;
         if (bus.avm_address !== m_addr) begin bad++; $display("FAIL rnd_address it=%0d got %h exp %h", i, bus.avm_address, m_addr); end
         do_write(d);
         addrs.push_back(a);
         total += 2;
         if (acc_data !== {16'h0, d} || acc_addr !== m_addr) begin
            bad++; $display("FAIL rnd_write it=%0d got %h@%h exp %h@%h", i, acc_data, acc_addr, {16'h0, d}, m_addr);
         end
         if (display_data !== m_disp) begin bad++; $display("FAIL rnd_wdisp it=%0d got %h exp %h", i, display_data, m_disp); end
         a = addrs[$urandom_range(0, addrs.size() - 1)];
         rd_lat = $urandom_range(0, 4);
         latch_addr(a);
         do_read();
         total++;
         if (display_data !== m_disp) begin bad++; $display("FAIL rnd_read it=%0d got %h exp %h", i, display_data, m_disp); end
      end
      wait_n = 0;
   endtask

   task automatic test_timeout();
      int h0 = rd_high;
      hang = 1;
      do_read();
      hang = 0;
      total += 4;
      if (rd_high - h0 != TMO) begin bad++; $display("FAIL tmo_high got %0d exp %0d", rd_high - h0, TMO); end
      if (display_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tmo_display got %h exp DEADBEEF", display_data); end
      if (error !== 1'b1) begin bad++; $display("FAIL tmo_error got %b exp 1", error); end
      if (bus.avm_read !== 1'b0) begin bad++; $display("FAIL tmo_read got %b exp 0", bus.avm_read); end
      do_write(16'h0042);
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL tmo_sticky got %b exp 1", error); end
      do_reset();
      total++;
      if (error !== 1'b0) begin bad++; $display("FAIL tmo_clear got %b exp 0", error); end
   endtask

   task automatic test_reset_mid_read();
      int r0, n;
      bit found;
      latch_addr(16'h0012);
      rd_lat = 6;
      r0 = rd_count;
      found = 0;
      add_data_sel = 1'b1;
      rdwr_cntl    = 1'b0;
      @(negedge clk);
      n_action = 1'b0;
      n = 0;
      while (!found && n < 60) begin
         @(negedge clk);
         n++;
         if (rd_count != r0 && busy && !bus.avm_read) found = 1;
      end
      n_action = 1'b1;
      total++;
      if (!found) begin bad++; $display("FAIL midrd_reach got no RD_WAIT after %0d cycles exp RD_WAIT", n); end
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      total += 4;
      if (display_data !== 32'h0) begin bad++; $display("FAIL midrd_display got %h exp 0", display_data); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrd_busy got %b exp 0", busy); end
      if (bus.avm_address !== 28'(BASE)) begin bad++; $display("FAIL midrd_address got %h exp %h", bus.avm_address, 28'(BASE)); end
      if (bus.avm_read !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL midrd_ctl got rd=%b err=%b exp 0 0", bus.avm_read, error); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (15) @(negedge clk);
      total += 2;
      if (display_data !== 32'h0) begin bad++; $display("FAIL midrd_late got %h exp 0", display_data); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrd_idle got %b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_addr_latch();
      test_write();
      test_read();
      test_bounce();
      test_random();
      test_timeout();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
